// File: rtl/aud_sample_fifo.sv
// Audio sample FIFO between a stream producer and an I2S transmitter's request/sample port.
// Optional underrun counter port is enabled by defining AUD_UNDERRUN_CNT_EN.
module aud_sample_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LOW_WATER = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [31:0]              s_data_i,
  input  logic                     req_i,
  output logic [31:0]              sample_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     low_o,
  output logic                     underrun_o
`ifdef AUD_UNDERRUN_CNT_EN
  ,
  output logic [15:0]              underrun_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LOW_LVL  = LW'(LOW_WATER);

  if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("aud_sample_fifo: DEPTH must be a power of two in 4..256");
  end
  if (LOW_WATER >= DEPTH) begin : g_bad_low_water
    $error("aud_sample_fifo: LOW_WATER must be below DEPTH");
  end

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   sample_q, sample_d;
  logic          low_q, low_d;
  logic          underrun_q, underrun_d;

  logic empty;
  logic push;
  logic pop;

  // Ready depends only on the registered level and reset, never on req_i.
  assign empty     = (level_q == '0);
  assign s_ready_o = rst_ni && (level_q != FULL_LVL);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = req_i && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    sample_d   = sample_q;
    underrun_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A request on an empty FIFO mutes the output; a same-cycle push never falls through.
    if (pop) begin
      sample_d = mem_q[rd_ptr_q];
    end else if (req_i) begin
      sample_d   = 32'h0000_0000;
      underrun_d = 1'b1;
    end

    low_d = (level_d <= LOW_LVL);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sample_q   <= 32'h0000_0000;
      low_q      <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sample_q   <= sample_d;
      low_q      <= low_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_o   = sample_q;
  assign level_o    = level_q;
  assign low_o      = low_q;
  assign underrun_o = underrun_q;

`ifdef AUD_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Counts alongside the pulse so the count and underrun_o change on the same edge.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      underrun_cnt_q <= 16'h0000;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_aud_sample_fifo.sv
// Scoreboard bench for aud_sample_fifo: stimulus queues expected sample/underrun per request,
// a negedge monitor checks each response one cycle after its request.
module tb_aud_sample_fifo;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = '0;
  logic        req_i = 1'b0;
  logic [31:0] sample_o;
  logic [4:0]  level_o;
  logic        low_o;
  logic        underrun_o;
`ifdef AUD_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  aud_sample_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .req_i      (req_i),
    .sample_o   (sample_o),
    .level_o    (level_o),
    .low_o      (low_o),
    .underrun_o (underrun_o)
`ifdef AUD_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] smp;
    logic        und;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input logic [31:0] smp, input logic und);
    exp_t e;
    e.smp = smp;
    e.und = und;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    s_valid_i = v;
    s_data_i  = d;
    req_i     = r;
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    req_i     = 1'b0;
  endtask

  task automatic check_level(input string name, input int n);
    check({name, "_level"}, 32'(level_o), 32'(n));
    check({name, "_low"}, 32'(low_o), 32'(n <= LOW_WATER));
    check({name, "_ready"}, 32'(s_ready_o), 32'(n != DEPTH));
  endtask

  // Monitor: knows only what happened at the last edge, compares against the scoreboard.
  logic        req_seen = 1'b0;
  logic        rst_seen = 1'b0;
  logic [31:0] last_smp = '0;

  always @(posedge clk) begin
    req_seen <= req_i;
    rst_seen <= !rst_ni;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      last_smp = '0;
      check("rst_sample", sample_o, 32'h0);
      check("rst_underrun", 32'(underrun_o), 32'h0);
    end else if (req_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        last_smp = e.smp;
        check("sample", sample_o, e.smp);
        check("underrun", 32'(underrun_o), 32'(e.und));
      end
    end else begin
      check("hold", sample_o, last_smp);
      check("no_underrun", 32'(underrun_o), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, ready held low during reset
    rst_ni = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 32'h9999_9999, 0);
    check("rst_ready", 32'(s_ready_o), 32'h0);
    check("rst_level", 32'(level_o), 32'h0);
    check("rst_low", 32'(low_o), 32'h1);
    rst_ni = 1'b1;
    cyc(0, 0, 0);
    check_level("idle", 0);

    // Three pushes, three requests in order
    cyc(1, 32'h1111_2222, 0);
    cyc(1, 32'h3333_4444, 0);
    cyc(1, 32'h5555_6666, 0);
    check_level("push3", 3);
    expect_resp(32'h1111_2222, 0); cyc(0, 0, 1);
    cyc(0, 0, 0);
    expect_resp(32'h3333_4444, 0); cyc(0, 0, 1);
    expect_resp(32'h5555_6666, 0); cyc(0, 0, 1);
    check_level("drain3", 0);

    // Request while empty
    expect_resp(32'h0, 1); cyc(0, 0, 1);
    check_level("under1", 0);
`ifdef AUD_UNDERRUN_CNT_EN
    check("cnt1", 32'(underrun_cnt_o), 32'd1);
`endif
    cyc(0, 0, 0);

    // Request and push together on empty: underrun, sample stored, no fall-through
    expect_resp(32'h0, 1); cyc(1, 32'hABCD_0123, 1);
    check_level("under_push", 1);
`ifdef AUD_UNDERRUN_CNT_EN
    check("cnt2", 32'(underrun_cnt_o), 32'd2);
`endif
    expect_resp(32'hABCD_0123, 0); cyc(0, 0, 1);
    check_level("after_under_push", 0);

    // Fill to full, overflow attempt ignored, pop with push at full
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'hA000_0000 + 32'(i), 0);
    check_level("full", DEPTH);
    cyc(1, 32'hDEAD_BEEF, 0);
    check_level("full_ovf", DEPTH);
    expect_resp(32'hA000_0000, 0); cyc(1, 32'hDEAD_BEEF, 1);
    check_level("full_pop", DEPTH - 1);
    for (int i = 1; i < DEPTH; i++) begin
      expect_resp(32'hA000_0000 + 32'(i), 0);
      cyc(0, 0, 1);
      if (i == DEPTH - 1 - LOW_WATER) check_level("at_low", LOW_WATER);
      if (i == DEPTH - 2 - LOW_WATER) check_level("above_low", LOW_WATER + 1);
    end
    check_level("drained", 0);

    // Streaming: prefill 8, 32 concurrent push/pop, drain 8 (back-to-back requests)
    for (int k = 0; k < 8; k++) cyc(1, 32'hC000_0000 + 32'(k), 0);
    check_level("prefill", 8);
    for (int k = 0; k < 32; k++) begin
      expect_resp(32'hC000_0000 + 32'(k), 0);
      cyc(1, 32'hC000_0000 + 32'(k + 8), 1);
      if (k % 8 == 7) check_level("stream", 8);
    end
    for (int k = 32; k < 40; k++) begin
      expect_resp(32'hC000_0000 + 32'(k), 0);
      cyc(0, 0, 1);
    end
    check_level("stream_end", 0);

    // Reset mid-operation at level 10
    for (int k = 0; k < 10; k++) cyc(1, 32'hE000_0000 + 32'(k), 0);
    check_level("lvl10", 10);
    rst_ni = 1'b0;
    cyc(0, 0, 0);
    check("midrst_level", 32'(level_o), 32'h0);
    check("midrst_low", 32'(low_o), 32'h1);
    check("midrst_sample", sample_o, 32'h0);
    check("midrst_ready", 32'(s_ready_o), 32'h0);
`ifdef AUD_UNDERRUN_CNT_EN
    check("cnt_rst", 32'(underrun_cnt_o), 32'd0);
`endif
    rst_ni = 1'b1;
    cyc(1, 32'hF00D_0001, 0);
    check_level("post_rst_push", 1);
    expect_resp(32'hF00D_0001, 0); cyc(0, 0, 1);
    expect_resp(32'h0, 1); cyc(0, 0, 1);
    check_level("post_rst_under", 0);
`ifdef AUD_UNDERRUN_CNT_EN
    check("cnt_after_rst", 32'(underrun_cnt_o), 32'd1);
`endif

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aud_sample_fifo.md
AUD_SAMPLE_FIFO -- requirements
Module: aud_sample_fifo

Interface
REQ-001 Parameter DEPTH, 16, number of 32-bit sample entries; SHALL be a power of two, 4..256.
REQ-002 Parameter LOW_WATER, 4, level at or below which low_o asserts; SHALL be < DEPTH.
REQ-003 Port clk_i  in  1  system clock; sole clock of the block.
REQ-004 Port rst_ni  in  1  reset, synchronous, active-low.
REQ-005 Port s_valid_i  in  1  producer sample valid.
REQ-006 Port s_ready_o  out  1  FIFO can accept a sample.
REQ-007 Port s_data_i  in  32  producer sample {left[31:16], right[15:0]}.
REQ-008 Port req_i  in  1  single-cycle next-sample request from the I2S transmitter.
REQ-009 Port sample_o  out  32  current sample presented to the transmitter's sample input.
REQ-010 Port level_o  out  $clog2(DEPTH)+1  number of stored entries.
REQ-011 Port low_o  out  1  level_o <= LOW_WATER.
REQ-012 Port underrun_o  out  1  single-cycle pulse: request arrived while empty.

Function
REQ-013 Push SHALL occur on a clk_i rising edge when s_valid_i && s_ready_o; s_data_i written at write pointer, pointer incremented modulo DEPTH.
REQ-014 s_ready_o SHALL equal (level_o != DEPTH), derived from registered level only; no combinational path from req_i.
REQ-015 Pop SHALL occur on the edge where req_i=1 and level_o != 0; head entry loaded into sample_o, read pointer incremented modulo DEPTH.
REQ-016 sample_o SHALL update exactly one clk_i cycle after the req_i cycle and hold stable until the next req_i.
REQ-017 req_i with level_o == 0 SHALL load sample_o with 32'h0000_0000 (mute), leave pointers unchanged, and pulse underrun_o high for one cycle, one cycle after req_i.
REQ-018 Simultaneous push and pop with 0 < level_o < DEPTH: both SHALL take effect; level_o unchanged.
REQ-019 Simultaneous push and req_i with level_o == 0: SHALL be treated as underrun (REQ-017); the pushed sample SHALL be stored, level_o becomes 1; no fall-through.
REQ-020 Simultaneous req_i and s_valid_i with level_o == DEPTH: pop SHALL occur; push SHALL NOT (s_ready_o was 0); level_o becomes DEPTH-1.
REQ-021 level_o SHALL be a registered counter updated in the same edge as the pointers; never exceeds DEPTH, never underflows.
REQ-022 low_o SHALL be registered, valid in the same cycle as level_o.
REQ-023 req_i held high for N consecutive cycles SHALL be treated as N requests.

Reset
REQ-024 With rst_ni=0 on a clk_i rising edge: pointers=0, level_o=0, sample_o=0, underrun_o=0, low_o=1; storage contents need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard all stored samples; first push after release accepted on the first edge with rst_ni=1.
REQ-026 s_ready_o SHALL be 0 while rst_ni=0.

Configuration
REQ-027 Macro AUD_UNDERRUN_CNT_EN: when defined, port underrun_cnt_o out 16 SHALL exist, incrementing by 1 per underrun_o pulse, saturating at 16'hFFFF, cleared by reset.
REQ-028 Without AUD_UNDERRUN_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, push 3 samples 32'h1111_2222, 32'h3333_4444, 32'h5555_6666 -> level_o=3, low_o=1; three req_i pulses -> sample_o takes each value in order, 1 cycle after each req_i.
REQ-030 Push 16 samples (DEPTH=16) -> s_ready_o=0, level_o=16; 17th s_valid_i ignored; req_i with s_valid_i high -> level_o=15, pushed word not stored.
REQ-031 Empty FIFO, req_i -> sample_o=0, underrun_o one-cycle pulse, level_o stays 0; with AUD_UNDERRUN_CNT_EN underrun_cnt_o=1.
REQ-032 Empty FIFO, req_i and push 32'hABCD_0123 same cycle -> underrun pulse, sample_o=0, level_o=1; next req_i -> sample_o=32'hABCD_0123.
REQ-033 Stream 40 samples with concurrent push/pop at level 8 -> pointer wrap observed, output order matches input, no underrun pulses.
REQ-034 Assert rst_ni=0 at level 10 -> next cycle level_o=0, sample_o=0, low_o=1; following req_i -> underrun pulse.
